oam_dma: RTL and testbench
==========================

# oam_dma

Sprite-attribute DMA engine for the PPU. A CPU write to the DMA register starts a 160-byte copy from a 256-byte-aligned source page into OAM. The block acts as an initiator on the system read bus and as the writer into the PPU's OAM. It raises `busy` so the bus arbiter can lock the CPU out for the duration of the copy.

## Interface
- `BYTE_CYCLES`, default 4: clock cycles per transferred byte, one M-cycle; legal range is 2 or more.
- `LEN`, default 160: bytes per transfer; legal range 1..256.

- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `reg_write` in 1: register write strobe from the PPU register bus.
- `dma_sel` in 1: register select, high when the bus addresses the DMA register.
- `reg_in` in 8: write data, the source page.
- `reg_out` out 8: readback of the last written page. Combinational from the page register, valid regardless of `dma_sel`.
- `src_addr` out 16: read address on the system bus.
- `src_rd` out 1: read strobe, one cycle per byte.
- `src_data` in 8: read data, valid the cycle after `src_rd`.
- `oam_addr` out 8: OAM write index.
- `oam_wdata` out 8: OAM write data; combinational pass-through of `src_data`.
- `oam_we` out 1: OAM write strobe.
- `busy` out 1: high while in START or XFER.
- `oam_lock` out 1: high in XFER only; the PPU must not read OAM while it is high.

## Operation
- A trigger is `reg_write && dma_sel` at a rising edge.
  - On a trigger, the page register loads `reg_in` and the FSM goes to START.
  - A trigger in any state restarts the transfer.
- States:
  - IDLE: all strobes low; waits for a trigger.
  - START: startup delay of `BYTE_CYCLES` cycles, then XFER with byte index 0 and sub-counter 0.
  - XFER: one byte per `BYTE_CYCLES`-cycle slot.
    - Sub-cycle 0: `src_rd`=1 and `src_addr`={eff_page, idx}.
    - Sub-cycle 1: `oam_we`=1 and `oam_addr`=idx.
    - When the slot with idx=`LEN`-1 completes, the FSM returns to IDLE.
- eff_page:
  - Page 0xE0–0xFF maps to page−0x20 (echo RAM aliases to WRAM).
  - Any other page is used unchanged.
  - `reg_out` always returns the unmapped written value.
- Restart during START or XFER: the write slot of any in-flight byte is suppressed, so no `oam_we` occurs in the cycle after the trigger. The page, index and sub-counter are all reset.
- Byte index is 8 bits; the sub-counter is `$clog2(BYTE_CYCLES)` bits. Neither counter wraps, because the last slot ends the transfer.
- Reset values:
  - State is IDLE and the page register is 0xFF, so `reg_out`=0xFF.
  - `src_rd`, `oam_we`, `busy` and `oam_lock` are all 0.
  - `src_addr` and `oam_addr` are 0.
- Reset mid-transfer aborts the transfer. All strobes are low from the cycle after the reset edge, and the page returns to 0xFF.
- Reset has priority over a simultaneous trigger.

## Timing
- Trigger at edge T: `busy`=1 from cycle T+1.
- START occupies cycles T+1 .. T+`BYTE_CYCLES`. `oam_lock` rises at T+1+`BYTE_CYCLES`.
- Byte i slot starts at S_i = T+1+`BYTE_CYCLES`·(i+1).
  - `src_rd` is high during cycle S_i only.
  - `oam_we` is high during cycle S_i+1 only.
- The FSM is in IDLE at T+1+`BYTE_CYCLES`·(`LEN`+1). `busy` and `oam_lock` fall in that cycle.
- With default parameters, `busy` is high for 644 cycles and the last `oam_we` is at T+642.
- Trigger-to-first-read latency is `BYTE_CYCLES`+1 cycles.
- Every strobe is a single-cycle pulse. `src_rd` and `oam_we` are never high in the same cycle (guaranteed because `BYTE_CYCLES` ≥ 2).

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release → `reg_out`=0xFF, `busy`=0, no strobes for 10 idle cycles.
- **Basic copy:** write 0xC1 at T; the source model returns addr[7:0]^0x5A → first `src_rd` at T+5 with `src_addr`=0xC100.
  - 160 `oam_we` pulses occur with `oam_addr` 0..159 and data i^0x5A.
  - `busy` falls at T+645; `reg_out`=0xC1.
- **Echo mapping:** write 0xFE → `src_addr` runs 0xDE00..0xDE9F and `reg_out`=0xFE. Write 0xDF → `src_addr` runs 0xDF00..0xDF9F.
- **Restart:** write 0x80, then write 0x90 during the `src_rd` cycle of byte 50.
  - No `oam_we` occurs in the next cycle.
  - A new START follows, then `src_addr`=0x9000..0x909F.
  - OAM ends holding page 0x90 data for all 160 bytes.
- **Mid-transfer reset:** assert `rst_n`=0 at byte 20 → all outputs are at reset values the next cycle; no further `oam_we` until a new trigger.
- **Parameter sweep:** `BYTE_CYCLES`=2 and `LEN`=4 → `src_rd` at T+3, T+5, T+7, T+9; `oam_we` at T+4, T+6, T+8, T+10; `busy` falls at T+11.

Source files
------------

// File: rtl/oam_dma_if.sv
// rtl/oam_dma_if.sv - register, system read bus and OAM write signals of the sprite DMA
interface oam_dma_if;
  logic        reg_write;
  logic        dma_sel;
  logic [7:0]  reg_in;
  logic [7:0]  reg_out;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_data;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;

  modport master (
    input  reg_write, dma_sel, reg_in, src_data,
    output reg_out, src_addr, src_rd, oam_addr, oam_wdata, oam_we
  );

  modport slave (
    output reg_write, dma_sel, reg_in, src_data,
    input  reg_out, src_addr, src_rd, oam_addr, oam_wdata, oam_we
  );
endinterface

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite-attribute DMA: copies LEN bytes from a source page into OAM
module oam_dma #(
  parameter int BYTE_CYCLES = 4,
  parameter int LEN         = 160
) (
  input  logic      clk,
  input  logic      rst_n,
  oam_dma_if.master bus,
  output logic      busy,
  output logic      oam_lock
);
  localparam int             SW       = $clog2(BYTE_CYCLES);
  localparam logic [SW-1:0]  SUB_LAST = SW'(BYTE_CYCLES - 1);
  localparam logic [7:0]     IDX_LAST = 8'(LEN - 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t        state_q, state_d;
  logic [7:0]    page_q, page_d;
  logic [7:0]    idx_q, idx_d;
  logic [SW-1:0] sub_q, sub_d;
  logic          src_rd_q, src_rd_d;
  logic          oam_we_q, oam_we_d;
  logic          busy_q, busy_d;
  logic          lock_q, lock_d;
  logic [15:0]   src_addr_q, src_addr_d;
  logic [7:0]    oam_addr_q, oam_addr_d;
  logic [7:0]    eff_page;
  logic          trigger;

  assign trigger  = bus.reg_write && bus.dma_sel;
  // Echo RAM pages alias down onto WRAM.
  assign eff_page = (page_d >= 8'hE0) ? (page_d - 8'h20) : page_d;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    if (trigger) begin
      state_d = START;
      page_d  = bus.reg_in;
      idx_d   = 8'd0;
      sub_d   = '0;
    end else begin
      case (state_q)
        START: begin
          if (sub_q == SUB_LAST) begin
            state_d = XFER;
            sub_d   = '0;
            idx_d   = 8'd0;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
        XFER: begin
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (idx_q == IDX_LAST) state_d = IDLE;
            else                   idx_d   = idx_q + 8'd1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Strobes are registered, so they are derived from the state being entered.
    src_rd_d   = (state_d == XFER) && (sub_d == '0);
    oam_we_d   = (state_d == XFER) && (sub_d == SW'(1));
    src_addr_d = src_rd_d ? {eff_page, idx_d} : src_addr_q;
    oam_addr_d = oam_we_d ? idx_d : oam_addr_q;
    busy_d     = (state_d != IDLE);
    lock_d     = (state_d == XFER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      page_q     <= 8'hFF;
      idx_q      <= 8'd0;
      sub_q      <= '0;
      src_rd_q   <= 1'b0;
      oam_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      lock_q     <= 1'b0;
      src_addr_q <= 16'd0;
      oam_addr_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      sub_q      <= sub_d;
      src_rd_q   <= src_rd_d;
      oam_we_q   <= oam_we_d;
      busy_q     <= busy_d;
      lock_q     <= lock_d;
      src_addr_q <= src_addr_d;
      oam_addr_q <= oam_addr_d;
    end
  end

  assign bus.reg_out   = page_q;
  assign bus.src_addr  = src_addr_q;
  assign bus.src_rd    = src_rd_q;
  assign bus.oam_addr  = oam_addr_q;
  assign bus.oam_wdata = bus.src_data;
  assign bus.oam_we    = oam_we_q;
  assign busy          = busy_q;
  assign oam_lock      = lock_q;
endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - directed bench for oam_dma with a slot-arithmetic reference model
module tb_oam_dma;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oam_dma_if if0();
  oam_dma_if if1();
  logic busy0, lock0, busy1, lock1;

  oam_dma #(.BYTE_CYCLES(4), .LEN(160)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy0), .oam_lock(lock0));
  oam_dma #(.BYTE_CYCLES(2), .LEN(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1), .oam_lock(lock1));

  int vec = 0;
  int err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Source memory: byte at addr reads as addr[7:0]^0x5A; tag remembers the page read.
  logic [7:0] tag0, tag1;
  always @(posedge clk) begin
    if (if0.src_rd) begin
      if0.src_data <= if0.src_addr[7:0] ^ 8'h5A;
      tag0         <= if0.src_addr[15:8];
    end
    if (if1.src_rd) begin
      if1.src_data <= if1.src_addr[7:0] ^ 8'h5A;
      tag1         <= if1.src_addr[15:8];
    end
  end

  int         ecnt = 0;
  bit         seen_rst, rst_last;
  bit         act[2];
  int         trig[2];
  logic [7:0] pg[2] = '{8'hFF, 8'hFF};
  int         bcp[2] = '{4, 2};
  int         lenp[2] = '{160, 4};
  int         rd0[$], we0[$], rd1[$], we1[$];
  int         fall[2];
  bit         pbusy[2];
  logic [15:0] fa0, la0;
  logic [7:0] oam_mem[256], oam_tag[256];

  task automatic start(input int d, input logic [7:0] v);
    act[d] = 1'b1;
    trig[d] = ecnt;
    pg[d] = v;
    fall[d] = -1;
    if (d == 0) begin rd0.delete(); we0.delete(); end
    else begin rd1.delete(); we1.delete(); end
  endtask

  always @(posedge clk) begin
    ecnt++;
    rst_last = !rst_n;
    if (!rst_n) begin
      seen_rst = 1'b1;
      for (int d = 0; d < 2; d++) begin act[d] = 1'b0; pg[d] = 8'hFF; end
    end else begin
      if (if0.reg_write && if0.dma_sel) start(0, if0.reg_in);
      if (if1.reg_write && if1.dma_sel) start(1, if1.reg_in);
    end
  end

  // k counts cycles since the trigger edge: START for BYTE_CYCLES, then LEN slots.
  function automatic void expect_at(input int d, output logic b, output logic l,
                                    output logic r, output logic w, output logic [7:0] idx);
    int k, j;
    b = 0; l = 0; r = 0; w = 0; idx = 0;
    if (act[d]) begin
      k = ecnt - trig[d];
      if (k < bcp[d] * (lenp[d] + 1)) begin
        b = 1;
        if (k >= bcp[d]) begin
          j   = k - bcp[d];
          l   = 1;
          idx = 8'(j / bcp[d]);
          r   = (j % bcp[d]) == 0;
          w   = (j % bcp[d]) == 1;
        end
      end
    end
  endfunction

  task automatic cmp(input int d, input logic b, input logic l, input logic r, input logic w,
                     input logic [15:0] sa, input logic [7:0] oa, input logic [7:0] wd,
                     input logic [7:0] ro);
    logic eb, el, er, ew;
    logic [7:0] ei, eff;
    int rel;
    expect_at(d, eb, el, er, ew, ei);
    eff = (pg[d] >= 8'hE0) ? pg[d] - 8'h20 : pg[d];
    chk($sformatf("d%0d busy @%0d", d, ecnt), b, eb);
    chk($sformatf("d%0d oam_lock @%0d", d, ecnt), l, el);
    chk($sformatf("d%0d src_rd @%0d", d, ecnt), r, er);
    chk($sformatf("d%0d oam_we @%0d", d, ecnt), w, ew);
    chk($sformatf("d%0d reg_out @%0d", d, ecnt), ro, pg[d]);
    if (er) chk($sformatf("d%0d src_addr @%0d", d, ecnt), sa, {eff, ei});
    if (ew) begin
      chk($sformatf("d%0d oam_addr @%0d", d, ecnt), oa, ei);
      chk($sformatf("d%0d oam_wdata @%0d", d, ecnt), wd, ei ^ 8'h5A);
    end
    if (rst_last) begin
      chk($sformatf("d%0d rst src_addr @%0d", d, ecnt), sa, 0);
      chk($sformatf("d%0d rst oam_addr @%0d", d, ecnt), oa, 0);
    end
    rel = ecnt + 1 - trig[d];
    if (d == 0) begin
      if (r) begin
        if (rd0.size() == 0) fa0 = sa;
        la0 = sa;
        rd0.push_back(rel);
      end
      if (w) begin
        we0.push_back(rel);
        oam_mem[oa] = wd;
        oam_tag[oa] = tag0;
      end
    end else begin
      if (r) rd1.push_back(rel);
      if (w) we1.push_back(rel);
    end
    if (pbusy[d] && !b) fall[d] = rel;
    pbusy[d] = b;
  endtask

  always @(negedge clk) begin
    if (seen_rst) begin
      cmp(0, busy0, lock0, if0.src_rd, if0.oam_we, if0.src_addr, if0.oam_addr, if0.oam_wdata, if0.reg_out);
      cmp(1, busy1, lock1, if1.src_rd, if1.oam_we, if1.src_addr, if1.oam_addr, if1.oam_wdata, if1.reg_out);
    end
  end

  task automatic pulse(input int d, input logic [7:0] v);
    if (d == 0) begin if0.reg_write = 1; if0.dma_sel = 1; if0.reg_in = v; end
    else        begin if1.reg_write = 1; if1.dma_sel = 1; if1.reg_in = v; end
    @(posedge clk); #1;
    if0.reg_write = 0; if0.dma_sel = 0;
    if1.reg_write = 0; if1.dma_sel = 0;
  endtask

  function automatic int last_of(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1;
  endfunction

  int exp_rd[4] = '{3, 5, 7, 9};
  int exp_we[4] = '{4, 6, 8, 10};
  int n_we, bad;

  initial begin
    if0.reg_write = 0; if0.dma_sel = 0; if0.reg_in = 0;
    if1.reg_write = 0; if1.dma_sel = 0; if1.reg_in = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("reset reg_out", if0.reg_out, 8'hFF);
    chk("idle no reads", rd0.size(), 0);

    // Write without select and select without write must not trigger.
    if0.reg_write = 1; if0.reg_in = 8'h44;
    @(posedge clk); #1;
    if0.reg_write = 0; if0.dma_sel = 1;
    @(posedge clk); #1;
    if0.dma_sel = 0;
    repeat (2) @(posedge clk); #1;
    chk("no trigger busy", busy0, 0);
    chk("no trigger reg_out", if0.reg_out, 8'hFF);

    pulse(0, 8'hC1);
    repeat (650) @(posedge clk); #1;
    chk("basic first rd rel", (rd0.size() > 0) ? rd0[0] : -1, 5);
    chk("basic first addr", fa0, 16'hC100);
    chk("basic we count", we0.size(), 160);
    chk("basic last we rel", last_of(we0), 642);
    chk("basic busy fall rel", fall[0], 645);
    chk("basic reg_out", if0.reg_out, 8'hC1);

    pulse(0, 8'hFE);
    repeat (650) @(posedge clk); #1;
    chk("echo FE first addr", fa0, 16'hDE00);
    chk("echo FE last addr", la0, 16'hDE9F);
    chk("echo FE reg_out", if0.reg_out, 8'hFE);
    pulse(0, 8'hDF);
    repeat (650) @(posedge clk); #1;
    chk("page DF first addr", fa0, 16'hDF00);
    chk("page DF last addr", la0, 16'hDF9F);

    for (int i = 0; i < 256; i++) begin oam_tag[i] = 8'h00; oam_mem[i] = 8'h00; end
    pulse(0, 8'h80);
    repeat (204) @(posedge clk); #1;
    chk("restart at byte50 rd", if0.src_rd, 1);
    chk("restart at byte50 addr", if0.src_addr, 16'h8032);
    pulse(0, 8'h90);
    chk("restart no we", if0.oam_we, 0);
    chk("restart busy", busy0, 1);
    repeat (650) @(posedge clk); #1;
    chk("restart first addr", fa0, 16'h9000);
    chk("restart last addr", la0, 16'h909F);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (oam_tag[i] !== 8'h90 || oam_mem[i] !== (8'(i) ^ 8'h5A)) bad++;
    chk("restart oam image bad entries", bad, 0);

    pulse(0, 8'h33);
    repeat (84) @(posedge clk); #1;
    chk("midreset at byte20 addr", if0.src_addr, 16'h3314);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("midreset busy", busy0, 0);
    chk("midreset src_rd", if0.src_rd, 0);
    chk("midreset reg_out", if0.reg_out, 8'hFF);
    n_we = we0.size();
    repeat (100) @(posedge clk); #1;
    chk("midreset no further we", we0.size(), n_we);

    pulse(1, 8'h12);
    repeat (15) @(posedge clk); #1;
    chk("sweep rd count", rd1.size(), 4);
    chk("sweep we count", we1.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sweep rd%0d rel", i), (rd1.size() > i) ? rd1[i] : -1, exp_rd[i]);
      chk($sformatf("sweep we%0d rel", i), (we1.size() > i) ? we1[i] : -1, exp_we[i]);
    end
    chk("sweep busy fall rel", fall[1], 11);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
